// File: rtl/sdrc_bram_responder.sv
// BRAM-backed stand-in for the SDRAM controller user port: ACTIVE/WRITE/READ/PRECHARGE with fixed latencies.
// Ack after T_RCD / len+T_WR / READ_LATENCY+len+1 edges; commands outside IDLE are refused and flag O_protocol_error.
module sdrc_bram_responder #(
  parameter int ADDRESS_BIT_WIDTH = 12,
  parameter int INIT_CYCLES       = 16,
  parameter int T_RCD             = 2,
  parameter int T_WR              = 2,
  parameter int READ_LATENCY      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic        I_sdrc_precharge_ctrl,
  input  logic        I_sdram_power_down,
  input  logic        I_sdram_selfrefresh,
  input  logic [20:0] I_sdrc_addr,
  input  logic [3:0]  I_sdrc_dqm,
  input  logic [31:0] I_sdrc_data,
  input  logic [7:0]  I_sdrc_data_len,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_data_valid,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack,
  output logic        O_protocol_error
);
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_PRE = 3'b010;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACT_WAIT, S_WR_BURST, S_WR_RECOVER, S_RD_LAT, S_RD_BURST, S_SHORT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt;
  logic [8:0]  r_beat;
  logic [7:0]  r_len;
  logic [1:0]  r_bank;
  logic [10:0] r_row;
  logic [7:0]  r_col;
  logic        r_ap;
  logic [3:0]  r_row_vld;
  logic [10:0] r_row_tab [0:3];
  logic        r_init_done, r_ack, r_err, r_dvld;
  logic [31:0] r_dat;
  logic [31:0] r_mem [0:(1<<ADDRESS_BIT_WIDTH)-1];

  logic        w_complete, w_init_fin, w_accept, w_beat_vld, w_wr_en;
  logic        w_bank_open, w_row_hit;
  logic [3:0]  w_close_mask;
  logic [1:0]  w_bank;
  logic [10:0] w_row;
  logic [20:0] w_cur_addr, w_wr_addr;

  assign w_bank     = I_sdrc_addr[20:19];
  assign w_row      = I_sdrc_addr[18:8];
  // Column arithmetic is 8 bits wide so bursts wrap inside the open page.
  assign w_cur_addr = {r_bank, r_row, 8'(r_col + r_beat[7:0])};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_complete   = 1'b0;
    w_init_fin   = 1'b0;
    w_beat_vld   = 1'b0;
    w_close_mask = 4'b0000;
    case (r_state)
      S_INIT:       if (r_cnt == 16'(INIT_CYCLES - 1)) begin
                      w_init_fin  = 1'b1;
                      w_state_nxt = S_IDLE;
                    end
      S_ACT_WAIT:   if (r_cnt == 16'(T_RCD - 1)) w_complete = 1'b1;
      S_WR_BURST:   if (r_beat == {1'b0, r_len}) w_state_nxt = S_WR_RECOVER;
      S_WR_RECOVER: if (r_cnt == 16'(T_WR - 1)) w_complete = 1'b1;
      S_RD_LAT:     if (r_cnt == 16'(READ_LATENCY - 2)) w_state_nxt = S_RD_BURST;
      S_RD_BURST:   if (r_beat == {1'b0, r_len} + 9'd1) w_complete = 1'b1;
                    else w_beat_vld = 1'b1;
      S_SHORT:      w_complete = 1'b1;
      default:      ;
    endcase
    if (w_complete) begin
      w_state_nxt = S_IDLE;
      if (r_ap && (r_state == S_WR_RECOVER || r_state == S_RD_BURST))
        w_close_mask[r_bank] = 1'b1;
    end
    // A command may be taken on the very edge the previous one completes.
    w_accept = I_sdrc_cmd_en && r_init_done && !I_sdram_power_down && !I_sdram_selfrefresh &&
               (r_state == S_IDLE || w_complete);
    if (w_accept) begin
      case (I_sdrc_cmd)
        C_ACT:   w_state_nxt = S_ACT_WAIT;
        C_WR:    w_state_nxt = (I_sdrc_data_len == 8'd0) ? S_WR_RECOVER : S_WR_BURST;
        C_RD:    w_state_nxt = S_RD_LAT;
        default: w_state_nxt = S_SHORT;
      endcase
    end
    w_bank_open = r_row_vld[w_bank] && !w_close_mask[w_bank];
    w_row_hit   = w_bank_open && (r_row_tab[w_bank] == w_row);
    w_wr_en     = !rst && ((w_accept && I_sdrc_cmd == C_WR) || r_state == S_WR_BURST);
    w_wr_addr   = (r_state == S_WR_BURST) ? w_cur_addr : I_sdrc_addr;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!I_sdrc_dqm[b]) r_mem[w_wr_addr[ADDRESS_BIT_WIDTH-1:0]][8*b +: 8] <= I_sdrc_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_beat      <= '0;
      r_len       <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_ap        <= 1'b0;
      r_row_vld   <= '0;
      for (int i = 0; i < 4; i++) r_row_tab[i] <= '0;
      r_init_done <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dvld      <= 1'b0;
      r_dat       <= '0;
    end else begin
      r_cnt  <= (w_accept || w_state_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
      r_dvld <= w_beat_vld;
      if (w_init_fin) r_init_done <= 1'b1;
      if (w_beat_vld || r_state == S_WR_BURST) r_beat <= r_beat + 9'd1;
      if (w_beat_vld) r_dat <= r_mem[w_cur_addr[ADDRESS_BIT_WIDTH-1:0]];
      if (w_complete) r_ack <= 1'b1;
      r_row_vld <= r_row_vld & ~w_close_mask;
      if (I_sdrc_cmd_en && !w_accept) r_err <= 1'b1;
      if (w_accept) begin
        r_ack  <= 1'b0;
        r_bank <= w_bank;
        r_row  <= w_row;
        r_col  <= I_sdrc_addr[7:0];
        r_len  <= I_sdrc_data_len;
        r_ap   <= I_sdrc_precharge_ctrl;
        r_beat <= (I_sdrc_cmd == C_WR) ? 9'd1 : 9'd0;
        case (I_sdrc_cmd)
          C_ACT: begin
            if (w_bank_open) r_err <= 1'b1;
            r_row_vld[w_bank] <= 1'b1;
            r_row_tab[w_bank] <= w_row;
          end
          C_WR, C_RD: if (!w_row_hit) r_err <= 1'b1;
          C_PRE:   r_row_vld <= 4'b0000;
          default: ;
        endcase
      end
    end
  end

  assign O_sdrc_data       = r_dat;
  assign O_sdrc_data_valid = r_dvld;
  assign O_sdrc_init_done  = r_init_done;
  assign O_sdrc_cmd_ack    = r_ack;
  assign O_protocol_error  = r_err;
endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Directed bench for sdrc_bram_responder with default parameters (INIT 16, T_RCD 2, T_WR 2, READ_LATENCY 4).
module tb_sdrc_bram_responder;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_PRE = 3'b010;

  logic        clk = 1'b0;
  logic        rst, cmd_en, pc, pd, sr;
  logic [2:0]  cmd;
  logic [20:0] addr;
  logic [3:0]  dqm;
  logic [31:0] wdat;
  logic [7:0]  len;
  logic [31:0] rdat;
  logic        rvld, init_done, ack, perr;

  int checks = 0;
  int errors = 0;
  logic [31:0] wbuf [0:15];
  logic [3:0]  mbuf [0:15];
  logic [31:0] rbuf [0:15];
  int first_e, nbeats, ack_e;

  always #5 clk = ~clk;

  sdrc_bram_responder dut (
    .clk(clk), .rst(rst),
    .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_precharge_ctrl(pc),
    .I_sdram_power_down(pd), .I_sdram_selfrefresh(sr),
    .I_sdrc_addr(addr), .I_sdrc_dqm(dqm), .I_sdrc_data(wdat), .I_sdrc_data_len(len),
    .O_sdrc_data(rdat), .O_sdrc_data_valid(rvld), .O_sdrc_init_done(init_done),
    .O_sdrc_cmd_ack(ack), .O_protocol_error(perr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_en = 1'b0; pd = 1'b0; sr = 1'b0;
    tick; tick;
    rst = 1'b0;
    repeat (16) tick;
  endtask

  task automatic issue(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l, input logic p);
    cmd = c; addr = a; len = l; pc = p; wdat = wbuf[0]; dqm = mbuf[0];
    cmd_en = 1'b1;
    tick;
    cmd_en = 1'b0;
  endtask

  task automatic wait_ack(output int e);
    int n = 0;
    while (ack !== 1'b1 && n < 400) begin tick; n++; end
    e = (ack === 1'b1) ? n : -1;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [20:0] a, input logic p, output int e);
    issue(c, a, 8'd0, p);
    wait_ack(e);
  endtask

  task automatic do_write(input logic [20:0] a, input int l, input logic p, output int e);
    int n;
    issue(C_WR, a, 8'(l), p);
    for (int k = 1; k <= l; k++) begin wdat = wbuf[k]; dqm = mbuf[k]; tick; end
    dqm = 4'b0000;
    wait_ack(n);
    e = (n < 0) ? -1 : l + n;
  endtask

  task automatic do_read(input logic [20:0] a, input int l, input logic p);
    int n = 0;
    issue(C_RD, a, 8'(l), p);
    first_e = -1; nbeats = 0;
    while (ack !== 1'b1 && n < 600) begin
      tick; n++;
      if (rvld === 1'b1) begin
        if (first_e < 0) first_e = n;
        if (nbeats < 16) rbuf[nbeats] = rdat;
        nbeats++;
      end
    end
    ack_e = (ack === 1'b1) ? n : -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_en = 1'b0; cmd = 3'd0; pc = 1'b0; pd = 1'b0; sr = 1'b0;
    addr = '0; dqm = '0; wdat = '0; len = '0;
    tick; tick;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", perr); end
    checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rvld); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", rdat); end
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick;
      checks++;
      if (init_done !== (e == 16)) begin errors++; $display("FAIL init_edge%0d got=%b exp=%b", e, init_done, e == 16); end
    end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL init_err got=%b exp=0", perr); end
  endtask

  task automatic test_init_misuse;
    rst = 1'b1; tick; tick; rst = 1'b0;
    tick; tick; tick;
    cmd = C_ACT; addr = '0; cmd_en = 1'b1; tick; cmd_en = 1'b0;
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL init_cmd_err got=%b exp=1", perr); end
    repeat (20) tick;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL init_cmd_ignored ack got=%b exp=0", ack); end
    do_reset;
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", perr); end
  endtask

  task automatic test_burst;
    logic [31:0] exp [0:7];
    int e;
    exp = '{32'h1234_5678, 32'habcd_ef01, 32'h5678_1010, 32'habcd_fefe,
            32'habce_ef01, 32'habcd_ef02, 32'habcd_ef03, 32'habcd_ef04};
    for (int k = 0; k < 8; k++) wbuf[k] = exp[k];
    do_cmd(C_ACT, 21'h0, 1'b0, e);
    checks++; if (e !== 2) begin errors++; $display("FAIL act_ack_edge got=%0d exp=2", e); end
    do_write(21'h0, 7, 1'b1, e);
    checks++; if (e !== 9) begin errors++; $display("FAIL wr_ack_edge got=%0d exp=9", e); end
    do_cmd(C_ACT, 21'h0, 1'b0, e);
    do_read(21'h0, 7, 1'b1);
    checks++; if (first_e !== 4) begin errors++; $display("FAIL rd_first_edge got=%0d exp=4", first_e); end
    checks++; if (nbeats !== 8) begin errors++; $display("FAIL rd_beats got=%0d exp=8", nbeats); end
    checks++; if (ack_e !== 12) begin errors++; $display("FAIL rd_ack_edge got=%0d exp=12", ack_e); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rbuf[k] !== exp[k]) begin errors++; $display("FAIL burst_beat%0d got=%h exp=%h", k, rbuf[k], exp[k]); end
    end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL burst_err got=%b exp=0", perr); end
  endtask

  task automatic test_row_sep;
    int e;
    do_cmd(C_PRE, 21'h0, 1'b0, e);
    checks++; if (e !== 1) begin errors++; $display("FAIL pre_ack_edge got=%0d exp=1", e); end
    wbuf[0] = 32'h1010_2020; wbuf[1] = 32'habcd_ef01; wbuf[2] = 32'h5678_1010; wbuf[3] = 32'habcd_fefe;
    do_cmd(C_ACT, 21'h100, 1'b0, e);
    do_write(21'h100, 3, 1'b1, e);
    wbuf[0] = 32'h1e1f_2a2b;
    do_cmd(C_ACT, 21'h200, 1'b0, e);
    do_write(21'h204, 0, 1'b1, e);
    checks++; if (e !== 2) begin errors++; $display("FAIL wr1_ack_edge got=%0d exp=2", e); end
    do_cmd(C_ACT, 21'h100, 1'b0, e);
    do_read(21'h100, 3, 1'b0);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL row1_beats got=%0d exp=4", nbeats); end
    checks++; if (rbuf[0] !== 32'h1010_2020) begin errors++; $display("FAIL row1_beat0 got=%h exp=10102020", rbuf[0]); end
    checks++; if (rbuf[3] !== 32'habcd_fefe) begin errors++; $display("FAIL row1_beat3 got=%h exp=abcdfefe", rbuf[3]); end
    do_read(21'h101, 0, 1'b1);
    checks++; if (rbuf[0] !== 32'habcd_ef01) begin errors++; $display("FAIL row1_col1 got=%h exp=abcdef01", rbuf[0]); end
    checks++; if (ack_e !== 5) begin errors++; $display("FAIL rd1_ack_edge got=%0d exp=5", ack_e); end
    do_cmd(C_ACT, 21'h200, 1'b0, e);
    do_read(21'h204, 0, 1'b1);
    checks++; if (rbuf[0] !== 32'h1e1f_2a2b) begin errors++; $display("FAIL row2_col4 got=%h exp=1e1f2a2b", rbuf[0]); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rowsep_err got=%b exp=0", perr); end
  endtask

  task automatic test_byte_mask;
    int e;
    wbuf[0] = 32'hffff_ffff; wbuf[1] = 32'hffff_ffff;
    do_cmd(C_ACT, 21'h300, 1'b0, e);
    do_write(21'h300, 1, 1'b0, e);
    wbuf[0] = 32'h0; wbuf[1] = 32'h0; mbuf[0] = 4'b1010; mbuf[1] = 4'b0101;
    do_write(21'h300, 1, 1'b1, e);
    mbuf[0] = 4'b0000; mbuf[1] = 4'b0000;
    do_cmd(C_ACT, 21'h300, 1'b0, e);
    do_read(21'h300, 1, 1'b1);
    checks++; if (rbuf[0] !== 32'hff00_ff00) begin errors++; $display("FAIL mask_1010 got=%h exp=ff00ff00", rbuf[0]); end
    checks++; if (rbuf[1] !== 32'h00ff_00ff) begin errors++; $display("FAIL mask_0101 got=%h exp=00ff00ff", rbuf[1]); end
  endtask

  task automatic test_col_wrap;
    int e;
    wbuf[0] = 32'hc0de_0001; wbuf[1] = 32'hc0de_0002; wbuf[2] = 32'hc0de_0003; wbuf[3] = 32'hc0de_0004;
    do_cmd(C_ACT, 21'h400, 1'b0, e);
    do_write(21'h4fe, 3, 1'b0, e);
    checks++; if (e !== 5) begin errors++; $display("FAIL wrap_wr_ack_edge got=%0d exp=5", e); end
    do_read(21'h400, 1, 1'b0);
    checks++; if (rbuf[0] !== 32'hc0de_0003) begin errors++; $display("FAIL wrap_col00 got=%h exp=c0de0003", rbuf[0]); end
    checks++; if (rbuf[1] !== 32'hc0de_0004) begin errors++; $display("FAIL wrap_col01 got=%h exp=c0de0004", rbuf[1]); end
    do_read(21'h4fe, 1, 1'b1);
    checks++; if (rbuf[0] !== 32'hc0de_0001) begin errors++; $display("FAIL wrap_colfe got=%h exp=c0de0001", rbuf[0]); end
    checks++; if (rbuf[1] !== 32'hc0de_0002) begin errors++; $display("FAIL wrap_colff got=%h exp=c0de0002", rbuf[1]); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b exp=0", perr); end
  endtask

  task automatic test_misuse;
    int e, n;
    logic seen;
    do_cmd(C_PRE, 21'h0, 1'b0, e);
    do_read(21'h100, 0, 1'b1);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL closed_rd_err got=%b exp=1", perr); end
    checks++; if (rbuf[0] !== 32'h1010_2020 || nbeats !== 1) begin errors++; $display("FAIL closed_rd_data got=%h/%0d exp=10102020/1", rbuf[0], nbeats); end
    do_reset;
    do_cmd(C_ACT, 21'h100, 1'b0, e);
    pd = 1'b1; issue(C_ACT, 21'h200, 8'd0, 1'b0); pd = 1'b0;
    repeat (5) tick;
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL pd_err got=%b exp=1", perr); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pd_ack_kept got=%b exp=1", ack); end
    do_reset;
    issue(C_ACT, 21'h100, 8'd0, 1'b0);
    cmd = C_RD; addr = 21'h100; cmd_en = 1'b1; tick; cmd_en = 1'b0;
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL busy_err got=%b exp=1", perr); end
    n = 1; seen = 1'b0;
    while (ack !== 1'b1 && n < 100) begin tick; n++; if (rvld === 1'b1) seen = 1'b1; end
    checks++; if (n !== 2) begin errors++; $display("FAIL busy_act_ack_edge got=%0d exp=2", n); end
    repeat (10) begin tick; if (rvld === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_cmd_ignored valid_seen got=%b exp=0", seen); end
    do_reset;
    do_cmd(C_ACT, 21'h100, 1'b0, e);
    do_cmd(C_ACT, 21'h180, 1'b0, e);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL reopen_err got=%b exp=1", perr); end
  endtask

  task automatic test_reset_mid_read;
    int e, n;
    do_reset;
    do_cmd(C_ACT, 21'h400, 1'b0, e);
    issue(C_RD, 21'h400, 8'd7, 1'b0);
    n = 0;
    while (rvld !== 1'b1 && n < 20) begin tick; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL midrd_first_edge got=%0d exp=4", n); end
    rst = 1'b1; tick;
    checks++; if (rvld !== 1'b0) begin errors++; $display("FAIL midrd_valid got=%b exp=0", rvld); end
    checks++; if (init_done !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL midrd_outs got=%b%b exp=00", init_done, ack); end
    rst = 1'b0;
    repeat (16) tick;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit got=%b exp=1", init_done); end
    do_cmd(C_ACT, 21'h400, 1'b0, e);
    do_read(21'h400, 1, 1'b1);
    checks++; if (rbuf[0] !== 32'hc0de_0003 || rbuf[1] !== 32'hc0de_0004) begin errors++; $display("FAIL kept_row4 got=%h %h exp=c0de0003 c0de0004", rbuf[0], rbuf[1]); end
    do_cmd(C_ACT, 21'h300, 1'b0, e);
    do_read(21'h300, 0, 1'b1);
    checks++; if (rbuf[0] !== 32'hff00_ff00) begin errors++; $display("FAIL kept_row3 got=%h exp=ff00ff00", rbuf[0]); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reinit_err got=%b exp=0", perr); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin wbuf[k] = '0; mbuf[k] = '0; rbuf[k] = '0; end
    test_reset;
    test_init_misuse;
    test_burst;
    test_row_sep;
    test_byte_mask;
    test_col_wrap;
    test_misuse;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
